cvmcu_pad_claim_arbiter: RTL and testbench
==========================================

Name: cvmcu_pad_claim_arbiter

Overview:
- Arbitrates pad ownership and pad configuration for the 48-pin CORE-V-MCU IO ring between NUM_REQ peripheral requesters (UART0/1, I2C, QSPI, CPI, SDIO agents/controllers).
- Round-robin grants one claim/release/reconfigure/query operation at a time and updates a per-pad ownership and config table.
- The table drives the pad_cfg bus and per-pad owner IDs consumed by the IO mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_PADS, 48, number of pads (1..64)
- CFG_W, 6, pad config width per pad
- CFG_RESET, 6'b000000, pad config value after reset or release
- ID_W, $clog2(NUM_REQ), owner ID width (derived, not overridable)

Ports:
- ref_clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester operation valid
- req_ready_o  out  NUM_REQ  per-requester accept; handshake = valid & ready
- req_op_i  in  2*NUM_REQ  op per requester: 00 CLAIM, 01 RELEASE, 10 RECONFIG, 11 QUERY
- req_pad_i  in  6*NUM_REQ  target pad index per requester
- req_cfg_i  in  CFG_W*NUM_REQ  config value per requester
- rsp_valid_o  out  NUM_REQ  one-cycle response strobe to the granted requester
- rsp_status_o  out  3  shared status, valid while any rsp_valid_o bit is high
- pad_cfg_o  out  CFG_W*NUM_PADS  current config per pad
- pad_owned_o  out  NUM_PADS  1 = pad has an owner
- pad_owner_o  out  ID_W*NUM_PADS  owner ID per pad, 0 when unowned
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: single clock ref_clk_i; reset rst_i is asynchronous, active-high.
- Reset values:
  - pad_cfg_o = CFG_RESET for all pads; pad_owned_o = 0; pad_owner_o = 0.
  - req_ready_o = 0; rsp_valid_o = 0; rsp_status_o = 000; busy_o = 0.
  - FSM = IDLE; round-robin pointer = 0.
- FSM states: IDLE -> CHECK -> COMMIT -> RESP -> IDLE.
- IDLE:
  - req_ready_o[g] = 1 (combinational) only for g = first valid requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - On handshake: latch op/pad/cfg/g, set RR pointer = (g+1) mod NUM_REQ, go to CHECK.
  - With no valid requester: all ready bits 0, stay in IDLE.
- CHECK: compute status from the latched request and the current table entry. Status priority, highest first:
  - BAD_PAD (010) if pad >= NUM_PADS.
  - CLAIM: pad owned by another ID -> OWNED (001); otherwise OK (000). Re-claim by the current owner is OK and updates cfg.
  - RELEASE / RECONFIG: pad unowned or owned by another ID -> NOT_OWNER (011); otherwise OK.
  - QUERY: OK if the pad is owned by g, else NOT_OWNER. Never modifies the table.
- COMMIT: write the table only if status is OK.
  - CLAIM: owned = 1, owner = g, cfg = latched cfg.
  - RELEASE: owned = 0, owner = 0, cfg = CFG_RESET.
  - RECONFIG: cfg = latched cfg.
- RESP:
  - rsp_valid_o[g] = 1 for exactly one cycle, with rsp_status_o valid in the same cycle.
  - Table outputs already reflect the update in this cycle.
  - Next state is IDLE.
- Timing: latency is 3 cycles from handshake to rsp_valid; peak throughput is one operation per 4 cycles.
- Requester rules:
  - A requester holds op/pad/cfg stable while valid is high and ready is low.
  - Dropping valid before ready is legal and has no effect.
- Requests arriving while busy_o = 1 are not accepted; they wait in IDLE arbitration.
- A requester holding valid after its response competes again under round-robin, so no requester starves (max wait = NUM_REQ-1 operations).
- Reset asserted mid-operation aborts the operation: no response, table restored to reset values.
- Table outputs are registered; there is no combinational path from req inputs to pad_* outputs.

Optional Feature:
- Macro: CVMCU_PAD_LOCK_EN.
- When defined:
  - Adds a per-pad lock bit and output pad_locked_o (NUM_PADS, reset 0).
  - op 11 becomes LOCK: the owner sets lock, status OK; a non-owner gets NOT_OWNER.
  - RELEASE/RECONFIG/re-CLAIM on a locked pad returns LOCKED (100) and leaves the table unchanged. LOCKED takes priority below BAD_PAD and above owner checks.
  - The lock clears only on rst_i.
- When undefined: op 11 is QUERY, status 100 is never produced, and pad_locked_o is absent.

Test Plan:
- Reset -> all pad_cfg_o = CFG_RESET, pad_owned_o = 0, busy_o = 0, no ready bits high.
- Req 1 CLAIM pad 7 cfg 6'h15 -> handshake; rsp_valid_o[1] 3 cycles later, status 000, pad_owner_o[7] = 1, pad_cfg_o[7] = 6'h15.
- Req 2 CLAIM pad 7 after the above -> status 001, pad 7 unchanged; req 2 RELEASE pad 7 -> status 011.
- Req 0 CLAIM pad 50 -> status 010, no table change; req 0 QUERY pad 3 (unowned) -> status 011.
- All 4 requesters hold valid continuously, pointer 0 -> grants in order 0,1,2,3,0; each response spaced 4 cycles apart.
- Reset asserted during CHECK of a CLAIM on pad 8 -> no rsp_valid, pad 8 unowned. With CVMCU_PAD_LOCK_EN: owner LOCK pad 8 then RELEASE -> status 100, pad_locked_o[8] = 1.

Source files
------------

// File: rtl/cvmcu_pad_claim_arbiter.sv
// cvmcu_pad_claim_arbiter
// Round-robin arbiter that serialises claim/release/reconfig/query requests
// from several peripheral requesters against a per-pad ownership and config
// table. The table feeds the IO mux through pad_cfg_o / pad_owned_o / pad_owner_o.
// Optional feature: define CVMCU_PAD_LOCK_EN to add per-pad lock bits,
// the pad_locked_o output and the LOCK operation (op 11).
module cvmcu_pad_claim_arbiter #(
   parameter int                 NUM_REQ   = 4,
   parameter int                 NUM_PADS  = 48,
   parameter int                 CFG_W     = 6,
   parameter logic [CFG_W-1:0]   CFG_RESET = '0,
   localparam int                ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      ref_clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [2*NUM_REQ-1:0]      req_op_i,
   input  logic [6*NUM_REQ-1:0]      req_pad_i,
   input  logic [CFG_W*NUM_REQ-1:0]  req_cfg_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [2:0]                rsp_status_o,
   output logic [CFG_W*NUM_PADS-1:0] pad_cfg_o,
   output logic [NUM_PADS-1:0]       pad_owned_o,
   output logic [ID_W*NUM_PADS-1:0]  pad_owner_o,
`ifdef CVMCU_PAD_LOCK_EN
   output logic [NUM_PADS-1:0]       pad_locked_o,
`endif
   output logic                      busy_o
);

   localparam int PAD_IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

   localparam logic [1:0] OP_CLAIM    = 2'b00;
   localparam logic [1:0] OP_RELEASE  = 2'b01;
   localparam logic [1:0] OP_RECONFIG = 2'b10;
`ifdef CVMCU_PAD_LOCK_EN
   localparam logic [1:0] OP_LOCK     = 2'b11;
   localparam logic [2:0] ST_LOCKED   = 3'b100;
`endif

   localparam logic [2:0] ST_OK        = 3'b000;
   localparam logic [2:0] ST_OWNED     = 3'b001;
   localparam logic [2:0] ST_BAD_PAD   = 3'b010;
   localparam logic [2:0] ST_NOT_OWNER = 3'b011;

   typedef enum logic [1:0] {IDLE, CHECK, COMMIT, RESP} state_t;

   state_t               state, state_nxt;
   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_found;
   logic [ID_W-1:0]      lat_id;
   logic [1:0]           lat_op;
   logic [5:0]           lat_pad;
   logic [CFG_W-1:0]     lat_cfg;
   logic [2:0]           status_q, status_nxt;
   logic                 pad_in_range;
   logic [PAD_IDX_W-1:0] pad_sel;
   logic                 owner_match;

   logic [CFG_W-1:0]     cfg_tbl   [NUM_PADS];
   logic [ID_W-1:0]      owner_tbl [NUM_PADS];
   logic [NUM_PADS-1:0]  owned_tbl;
`ifdef CVMCU_PAD_LOCK_EN
   logic [NUM_PADS-1:0]  locked_tbl;
`endif

   // Out-of-range pads are reported as BAD_PAD; the table is read at entry 0 so no index leaves the array
   assign pad_in_range = (int'(lat_pad) < NUM_PADS);
   assign pad_sel      = pad_in_range ? lat_pad[PAD_IDX_W-1:0] : '0;
   assign owner_match  = owned_tbl[pad_sel] && (owner_tbl[pad_sel] == lat_id);

   // Pick the first valid requester at or after the round-robin pointer, wrapping around
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && req_valid_i[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   // FSM state register
   always_ff @(posedge ref_clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; ready is offered only to the granted requester while idle
   always_comb begin
      state_nxt   = state;
      req_ready_o = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready_o[grant_id] = 1'b1;
               state_nxt             = CHECK;
            end
         end
         CHECK:   state_nxt = COMMIT;
         COMMIT:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status of the latched request against the current table entry, highest priority first
   always_comb begin
      status_nxt = ST_OK;
      if (!pad_in_range) begin
         status_nxt = ST_BAD_PAD;
      end
`ifdef CVMCU_PAD_LOCK_EN
      else if (locked_tbl[pad_sel] && (lat_op != OP_LOCK)) begin
         status_nxt = ST_LOCKED;
      end
`endif
      else if (lat_op == OP_CLAIM) begin
         if (owned_tbl[pad_sel] && !owner_match) status_nxt = ST_OWNED;
      end else begin
         if (!owner_match) status_nxt = ST_NOT_OWNER;
      end
   end

   // Request latch, round-robin pointer advance and status capture
   always_ff @(posedge ref_clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr   <= '0;
         lat_id   <= '0;
         lat_op   <= '0;
         lat_pad  <= '0;
         lat_cfg  <= '0;
         status_q <= ST_OK;
      end else begin
         if (state == IDLE && grant_found) begin
            lat_id  <= grant_id;
            lat_op  <= req_op_i[2*int'(grant_id) +: 2];
            lat_pad <= req_pad_i[6*int'(grant_id) +: 6];
            lat_cfg <= req_cfg_i[CFG_W*int'(grant_id) +: CFG_W];
            rr_ptr  <= (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + ID_W'(1);
         end
         if (state == CHECK) status_q <= status_nxt;
      end
   end

   // Pad table: written once per operation in COMMIT, only when the operation succeeded
   always_ff @(posedge ref_clk_i or posedge rst_i) begin
      if (rst_i) begin
         owned_tbl <= '0;
`ifdef CVMCU_PAD_LOCK_EN
         locked_tbl <= '0;
`endif
         for (int p = 0; p < NUM_PADS; p++) begin
            cfg_tbl[p]   <= CFG_RESET;
            owner_tbl[p] <= '0;
         end
      end else if (state == COMMIT && status_q == ST_OK) begin
         case (lat_op)
            OP_CLAIM: begin
               owned_tbl[pad_sel] <= 1'b1;
               owner_tbl[pad_sel] <= lat_id;
               cfg_tbl[pad_sel]   <= lat_cfg;
            end
            OP_RELEASE: begin
               owned_tbl[pad_sel] <= 1'b0;
               owner_tbl[pad_sel] <= '0;
               cfg_tbl[pad_sel]   <= CFG_RESET;
            end
            OP_RECONFIG: begin
               cfg_tbl[pad_sel]   <= lat_cfg;
            end
            default: begin
`ifdef CVMCU_PAD_LOCK_EN
               locked_tbl[pad_sel] <= 1'b1;
`endif
            end
         endcase
      end
   end

   // Flatten the table onto the pad buses consumed by the IO mux
   always_comb begin
      pad_cfg_o   = '0;
      pad_owner_o = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         pad_cfg_o[p*CFG_W +: CFG_W] = cfg_tbl[p];
         pad_owner_o[p*ID_W +: ID_W] = owner_tbl[p];
      end
   end

   // Response strobe goes to the requester that owns the operation in flight
   always_comb begin
      rsp_valid_o = '0;
      if (state == RESP) rsp_valid_o[lat_id] = 1'b1;
   end

   assign rsp_status_o = (state == RESP) ? status_q : ST_OK;
   assign pad_owned_o  = owned_tbl;
   assign busy_o       = (state != IDLE);
`ifdef CVMCU_PAD_LOCK_EN
   assign pad_locked_o = locked_tbl;
`endif

endmodule

// File: tb/tb_cvmcu_pad_claim_arbiter.sv
// Testbench for cvmcu_pad_claim_arbiter: directed scenarios followed by
// randomized requester traffic, all checked against an operation-level model.
module tb_cvmcu_pad_claim_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int NUM_PADS = 48;
   localparam int CFG_W    = 6;
   localparam int ID_W     = 2;

   logic                      ref_clk_i = 1'b0;
   logic                      rst_i;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [2*NUM_REQ-1:0]      req_op_i;
   logic [6*NUM_REQ-1:0]      req_pad_i;
   logic [CFG_W*NUM_REQ-1:0]  req_cfg_i;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [2:0]                rsp_status_o;
   logic [CFG_W*NUM_PADS-1:0] pad_cfg_o;
   logic [NUM_PADS-1:0]       pad_owned_o;
   logic [ID_W*NUM_PADS-1:0]  pad_owner_o;
   logic                      busy_o;
`ifdef CVMCU_PAD_LOCK_EN
   logic [NUM_PADS-1:0]       pad_locked_o;
`endif

   cvmcu_pad_claim_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .NUM_PADS (NUM_PADS),
      .CFG_W    (CFG_W),
      .CFG_RESET(6'b000000)
   ) dut (
      .ref_clk_i   (ref_clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_op_i    (req_op_i),
      .req_pad_i   (req_pad_i),
      .req_cfg_i   (req_cfg_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_status_o(rsp_status_o),
      .pad_cfg_o   (pad_cfg_o),
      .pad_owned_o (pad_owned_o),
      .pad_owner_o (pad_owner_o),
`ifdef CVMCU_PAD_LOCK_EN
      .pad_locked_o(pad_locked_o),
`endif
      .busy_o      (busy_o)
   );

   // Free-running 100 MHz clock
   always #5 ref_clk_i = ~ref_clk_i;

   int n_checks = 0;
   int n_errors = 0;
   bit random_mode = 1'b0;

   // Requester-side request registers
   bit         v_valid [NUM_REQ];
   logic [1:0] v_op    [NUM_REQ];
   logic [5:0] v_pad   [NUM_REQ];
   logic [5:0] v_cfg   [NUM_REQ];

   // Reference model: operation-level view of the arbiter and the pad table
   int         m_phase;
   int         m_ptr;
   int         m_g;
   logic [1:0] m_op;
   int         m_pad;
   logic [5:0] m_cfg;
   logic [2:0] m_status;
   bit         m_owned  [NUM_PADS];
   int         m_owner  [NUM_PADS];
   logic [5:0] m_cfgt   [NUM_PADS];
   bit         m_locked [NUM_PADS];

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic packInputs();
      for (int r = 0; r < NUM_REQ; r++) begin
         req_valid_i[r]       = v_valid[r];
         req_op_i[2*r +: 2]   = v_op[r];
         req_pad_i[6*r +: 6]  = v_pad[r];
         req_cfg_i[6*r +: 6]  = v_cfg[r];
      end
   endtask

   task automatic modelReset();
      m_phase = 0;
      m_ptr   = 0;
      m_g     = 0;
      for (int p = 0; p < NUM_PADS; p++) begin
         m_owned[p]  = 1'b0;
         m_owner[p]  = 0;
         m_cfgt[p]   = 6'd0;
         m_locked[p] = 1'b0;
      end
   endtask

   task automatic setReq(input int r, input logic [1:0] op, input logic [5:0] pad, input logic [5:0] cfg);
      v_valid[r] = 1'b1;
      v_op[r]    = op;
      v_pad[r]   = pad;
      v_cfg[r]   = cfg;
      packInputs();
   endtask

   task automatic newRequest(input int r);
      int sel;
      sel = $urandom_range(0, 10);
      if (sel < 8)       v_pad[r] = 6'(sel);
      else if (sel == 8) v_pad[r] = 6'd47;
      else if (sel == 9) v_pad[r] = 6'd50;
      else               v_pad[r] = 6'd63;
      v_valid[r] = 1'b1;
      v_op[r]    = 2'($urandom_range(0, 3));
      v_cfg[r]   = 6'($urandom_range(0, 63));
   endtask

   // Apply the rules of one granted operation to the model table
   task automatic resolveOp();
      bit mine;
      mine = 1'b0;
      if (m_pad >= NUM_PADS) begin
         m_status = 3'b010;
      end else begin
         mine = m_owned[m_pad] && (m_owner[m_pad] == m_g);
`ifdef CVMCU_PAD_LOCK_EN
         if (m_locked[m_pad] && m_op != 2'b11) m_status = 3'b100; else
`endif
         if (m_op == 2'b00) m_status = (m_owned[m_pad] && !mine) ? 3'b001 : 3'b000;
         else               m_status = mine ? 3'b000 : 3'b011;
         if (m_status == 3'b000) begin
            case (m_op)
               2'b00: begin m_owned[m_pad] = 1'b1; m_owner[m_pad] = m_g; m_cfgt[m_pad] = m_cfg; end
               2'b01: begin m_owned[m_pad] = 1'b0; m_owner[m_pad] = 0;   m_cfgt[m_pad] = 6'd0;  end
               2'b10: m_cfgt[m_pad] = m_cfg;
               default: begin
`ifdef CVMCU_PAD_LOCK_EN
                  m_locked[m_pad] = 1'b1;
`endif
               end
            endcase
         end
      end
   endtask

   task automatic checkTable();
      logic [CFG_W*NUM_PADS-1:0] exp_cfg;
      logic [NUM_PADS-1:0]       exp_owned;
      logic [ID_W*NUM_PADS-1:0]  exp_owner;
      logic [NUM_PADS-1:0]       exp_locked;
      for (int p = 0; p < NUM_PADS; p++) begin
         exp_cfg[p*CFG_W +: CFG_W] = m_cfgt[p];
         exp_owned[p]              = m_owned[p];
         exp_owner[p*ID_W +: ID_W] = ID_W'(m_owner[p]);
         exp_locked[p]             = m_locked[p];
      end
      checkOutput("pad_cfg", pad_cfg_o, exp_cfg);
      checkOutput("pad_owned", pad_owned_o, exp_owned);
      checkOutput("pad_owner", pad_owner_o, exp_owner);
`ifdef CVMCU_PAD_LOCK_EN
      checkOutput("pad_locked", pad_locked_o, exp_locked);
`endif
   endtask

   // Compare DUT outputs with the model, then advance the model by one clock
   task automatic modelStep(output int granted);
      logic [NUM_REQ-1:0] exp_ready;
      logic [NUM_REQ-1:0] exp_rsp;
      int g;
      int r;
      granted   = -1;
      g         = -1;
      exp_ready = '0;
      exp_rsp   = '0;
      if (m_phase == 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            r = (m_ptr + k) % NUM_REQ;
            if (g < 0 && v_valid[r]) g = r;
         end
      end
      if (g >= 0)       exp_ready[g]   = 1'b1;
      if (m_phase == 3) exp_rsp[m_g]   = 1'b1;
      checkOutput("req_ready", req_ready_o, exp_ready);
      checkOutput("busy", busy_o, (m_phase != 0));
      checkOutput("rsp_valid", rsp_valid_o, exp_rsp);
      if (m_phase == 3) begin
         checkOutput("rsp_status", rsp_status_o, m_status);
         checkTable();
      end
      case (m_phase)
         0: begin
            if (g >= 0) begin
               m_g     = g;
               m_op    = v_op[g];
               m_pad   = int'(v_pad[g]);
               m_cfg   = v_cfg[g];
               m_ptr   = (g + 1) % NUM_REQ;
               m_phase = 1;
               granted = g;
            end
         end
         1: m_phase = 2;
         2: begin resolveOp(); m_phase = 3; end
         default: m_phase = 0;
      endcase
   endtask

   // Requester behaviour after each clock edge: hold until accepted, then maybe issue a new one
   task automatic applyStimulus(input int granted);
      for (int r = 0; r < NUM_REQ; r++) begin
         if (r == granted) begin
            if (random_mode && $urandom_range(0, 3) != 0) newRequest(r);
            else v_valid[r] = 1'b0;
         end else if (random_mode) begin
            if (!v_valid[r]) begin
               if ($urandom_range(0, 2) == 0) newRequest(r);
            end else if ($urandom_range(0, 19) == 0) begin
               v_valid[r] = 1'b0;
            end
         end
      end
      packInputs();
   endtask

   task automatic stepCycle();
      int granted;
      @(negedge ref_clk_i);
      modelStep(granted);
      @(posedge ref_clk_i);
      #1;
      applyStimulus(granted);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Hard stop in case the stimulus ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset checks, directed scenarios, random traffic, reset mid-operation
   initial begin
      int n;
      rst_i = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
         v_valid[r] = 1'b0; v_op[r] = 2'b00; v_pad[r] = 6'd0; v_cfg[r] = 6'd0;
      end
      packInputs();
      modelReset();
      repeat (2) @(negedge ref_clk_i);
      checkOutput("reset_pad_cfg", pad_cfg_o, '0);
      checkOutput("reset_pad_owned", pad_owned_o, '0);
      checkOutput("reset_pad_owner", pad_owner_o, '0);
      checkOutput("reset_ready", req_ready_o, '0);
      checkOutput("reset_rsp_valid", rsp_valid_o, '0);
      checkOutput("reset_status", rsp_status_o, '0);
      checkOutput("reset_busy", busy_o, 1'b0);
      rst_i = 1'b0;
      @(posedge ref_clk_i);
      #1;

      $display("[TB] directed scenarios");
      setReq(1, 2'b00, 6'd7, 6'h15);
      runCycles(6);
      checkOutput("pad7_owner", pad_owner_o[7*ID_W +: ID_W], 2'd1);
      checkOutput("pad7_cfg", pad_cfg_o[7*CFG_W +: CFG_W], 6'h15);
      checkOutput("pad7_owned", pad_owned_o[7], 1'b1);
      setReq(2, 2'b00, 6'd7, 6'h2A);
      runCycles(6);
      setReq(2, 2'b01, 6'd7, 6'h00);
      runCycles(6);
      checkOutput("pad7_kept_cfg", pad_cfg_o[7*CFG_W +: CFG_W], 6'h15);
      setReq(0, 2'b00, 6'd50, 6'h3F);
      runCycles(6);
      setReq(0, 2'b11, 6'd3, 6'h00);
      runCycles(6);
      for (int r = 0; r < NUM_REQ; r++) setReq(r, 2'b00, 6'(10 + r), 6'(r + 1));
      runCycles(20);

      $display("[TB] random traffic");
      random_mode = 1'b1;
      runCycles(2000);
      random_mode = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) v_valid[r] = 1'b0;
      packInputs();
      n = 0;
      while (m_phase != 0 && n < 8) begin stepCycle(); n++; end
      runCycles(2);

      $display("[TB] reset during operation");
      setReq(0, 2'b00, 6'd8, 6'h2A);
      n = 0;
      while (m_phase != 1 && n < 8) begin stepCycle(); n++; end
      if (m_phase != 1) checkOutput("grant_timeout", 1'b0, 1'b1);
      rst_i = 1'b1;
      #1;
      modelReset();
      checkOutput("midrst_rsp_valid", rsp_valid_o, '0);
      checkOutput("midrst_busy", busy_o, 1'b0);
      checkOutput("midrst_pad_owned", pad_owned_o, '0);
      checkOutput("midrst_pad_cfg", pad_cfg_o, '0);
      @(negedge ref_clk_i);
      rst_i = 1'b0;
      @(posedge ref_clk_i);
      #1;
      runCycles(6);
      checkOutput("pad8_unowned", pad_owned_o[8], 1'b0);

`ifdef CVMCU_PAD_LOCK_EN
      $display("[TB] lock scenario");
      setReq(0, 2'b00, 6'd8, 6'h11);
      runCycles(6);
      setReq(0, 2'b11, 6'd8, 6'h00);
      runCycles(6);
      setReq(0, 2'b01, 6'd8, 6'h00);
      runCycles(6);
      checkOutput("pad8_locked", pad_locked_o[8], 1'b1);
      checkOutput("pad8_still_owned", pad_owned_o[8], 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
